hdmi_packet_scheduler: RTL and testbench

- Downstream consumer of the audio clock regeneration (ACR) packet generator, the audio sample packet assembler and the infoframe generators.
- Per data-island packet slot, picks one packet (ACR, audio sample, AVI infoframe, audio infoframe or null) and registers its header/subpackets for the TERC4/BCH packet assembler.
- Converts the ACR generator's toggle-style wrap signal into a pending request.
- Arbitrates fixed-priority with a starvation guard for infoframes.

---
 rtl/hdmi_packet_if.sv | 34 +++
 rtl/hdmi_packet_scheduler.sv | 122 ++++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hdmi_packet_if.sv
// Packet-slot bus between the packet sources and the HDMI data-island scheduler.
// Master drives requests and packet payloads; slave returns the selected packet.
interface hdmi_packet_if;
  logic              packet_enable;
  logic              video_field_end;
  logic              clk_audio_counter_wrap;
  logic [23:0]       acr_header;
  logic [3:0][55:0]  acr_sub;
  logic              audio_valid;
  logic              audio_ready;
  logic [23:0]       audio_header;
  logic [3:0][55:0]  audio_sub;
  logic [23:0]       avi_header;
  logic [3:0][55:0]  avi_sub;
  logic [23:0]       aif_header;
  logic [3:0][55:0]  aif_sub;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;
  logic [7:0]        packet_type;

  modport master (
    output packet_enable, video_field_end, clk_audio_counter_wrap,
    output acr_header, acr_sub, audio_valid, audio_header, audio_sub,
    output avi_header, avi_sub, aif_header, aif_sub,
    input  audio_ready, header, sub, packet_type
  );

  modport slave (
    input  packet_enable, video_field_end, clk_audio_counter_wrap,
    input  acr_header, acr_sub, audio_valid, audio_header, audio_sub,
    input  avi_header, avi_sub, aif_header, aif_sub,
    output audio_ready, header, sub, packet_type
  );
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// Per-slot data-island packet picker: ACR, audio, AVI/audio infoframe or null,
// fixed priority with a burst limit so audio cannot starve pending infoframes.
module hdmi_packet_scheduler #(
  parameter int MAX_AUDIO_BURST      = 4,
  parameter bit SEND_AUDIO_INFOFRAME = 1'b1
) (
  input  logic clk_pixel,
  input  logic rst_n,
  hdmi_packet_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_IDLE, SEL_NULL, SEL_ACR, SEL_AUDIO, SEL_AVI, SEL_AIF
  } sel_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_AUDIO_BURST);

  logic             wrap_q;
  logic             acr_pending;
  logic             avi_pending;
  logic             aif_pending;
  logic [3:0]       burst_cnt;
  logic [23:0]      header_q;
  logic [3:0][55:0] sub_q;
  logic [7:0]       type_q;

  logic             acr_evt;
  logic             if_pending;
  logic             forced_if;
  sel_t             sel;
  logic [23:0]      nxt_header;
  logic [3:0][55:0] nxt_sub;
  logic [7:0]       nxt_type;

  assign acr_evt    = bus.clk_audio_counter_wrap != wrap_q;
  assign if_pending = avi_pending | aif_pending;
  assign forced_if  = if_pending && (burst_cnt == BURST_MAX);

  always_comb begin
    sel = SEL_IDLE;
    if (bus.packet_enable) begin
      if (acr_pending)          sel = SEL_ACR;
      else if (forced_if)       sel = avi_pending ? SEL_AVI : SEL_AIF;
      else if (bus.audio_valid) sel = SEL_AUDIO;
      else if (avi_pending)     sel = SEL_AVI;
      else if (aif_pending)     sel = SEL_AIF;
      else                      sel = SEL_NULL;
    end
  end

  always_comb begin
    nxt_header = '0;
    nxt_sub    = '0;
    nxt_type   = 8'h00;
    case (sel)
      SEL_ACR: begin
        nxt_header = bus.acr_header;
        nxt_sub    = bus.acr_sub;
        nxt_type   = 8'h01;
      end
      SEL_AUDIO: begin
        nxt_header = bus.audio_header;
        nxt_sub    = bus.audio_sub;
        nxt_type   = 8'h02;
      end
      SEL_AVI: begin
        nxt_header = bus.avi_header;
        nxt_sub    = bus.avi_sub;
        nxt_type   = 8'h82;
      end
      SEL_AIF: begin
        nxt_header = bus.aif_header;
        nxt_sub    = bus.aif_sub;
        nxt_type   = 8'h84;
      end
      default: ;
    endcase
  end

  assign bus.audio_ready = (sel == SEL_AUDIO);
  assign bus.header      = header_q;
  assign bus.sub         = sub_q;
  assign bus.packet_type = type_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q      <= 1'b0;
      acr_pending <= 1'b0;
      avi_pending <= 1'b0;
      aif_pending <= 1'b0;
      burst_cnt   <= '0;
      header_q    <= '0;
      sub_q       <= '0;
      type_q      <= 8'h00;
    end else begin
      wrap_q <= bus.clk_audio_counter_wrap;
      // a new request in the same cycle as service wins over the clear
      acr_pending <= acr_evt
                   | (acr_pending & (sel != SEL_ACR));
      avi_pending <= bus.video_field_end
                   | (avi_pending & (sel != SEL_AVI));
      aif_pending <= (bus.video_field_end & SEND_AUDIO_INFOFRAME)
                   | (aif_pending & (sel != SEL_AIF));
      if (sel != SEL_IDLE) begin
        header_q <= nxt_header;
        sub_q    <= nxt_sub;
        type_q   <= nxt_type;
      end
      case (sel)
        SEL_AUDIO:
          if (!if_pending)
            burst_cnt <= '0;
          else if (burst_cnt != BURST_MAX)
            burst_cnt <= burst_cnt + 4'd1;
        SEL_AVI, SEL_AIF:
          burst_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler; a second instance with the audio
// infoframe disabled shares the same stimulus.
module tb_hdmi_packet_scheduler;

  localparam logic [23:0]  ACR_H = 24'h111101;
  localparam logic [23:0]  AUD_H = 24'h222202;
  localparam logic [23:0]  AVI_H = 24'h0D0282;
  localparam logic [23:0]  AIF_H = 24'h0A0184;
  localparam logic [223:0] ACR_S = {4{56'hA1A2A3A4A5A6A7}};
  localparam logic [223:0] AUD_S = {4{56'hB1B2B3B4B5B6B7}};
  localparam logic [223:0] AVI_S = {4{56'hC1C2C3C4C5C6C7}};
  localparam logic [223:0] AIF_S = {4{56'hD1D2D3D4D5D6D7}};

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hdmi_packet_if b0 ();
  hdmi_packet_if b1 ();

  hdmi_packet_scheduler #(
    .MAX_AUDIO_BURST(4),
    .SEND_AUDIO_INFOFRAME(1'b1)
  ) dut0 (
    .clk_pixel(clk),
    .rst_n(rst_n),
    .bus(b0.slave)
  );

  hdmi_packet_scheduler #(
    .MAX_AUDIO_BURST(4),
    .SEND_AUDIO_INFOFRAME(1'b0)
  ) dut1 (
    .clk_pixel(clk),
    .rst_n(rst_n),
    .bus(b1.slave)
  );

  assign b1.packet_enable          = b0.packet_enable;
  assign b1.video_field_end        = b0.video_field_end;
  assign b1.clk_audio_counter_wrap = b0.clk_audio_counter_wrap;
  assign b1.acr_header             = b0.acr_header;
  assign b1.acr_sub                = b0.acr_sub;
  assign b1.audio_valid            = b0.audio_valid;
  assign b1.audio_header           = b0.audio_header;
  assign b1.audio_sub              = b0.audio_sub;
  assign b1.avi_header             = b0.avi_header;
  assign b1.avi_sub                = b0.avi_sub;
  assign b1.aif_header             = b0.aif_header;
  assign b1.aif_sub                = b0.aif_sub;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one slot; ready values are sampled inside the packet_enable cycle
  task automatic slot(output logic rdy0, output logic rdy1);
    b0.packet_enable = 1'b1;
    #2;
    rdy0 = b0.audio_ready;
    rdy1 = b1.audio_ready;
    @(posedge clk);
    #1;
    b0.packet_enable = 1'b0;
  endtask

  logic       r0, r1;
  logic [7:0] pat [10];

  initial begin
    pat = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h82,
            8'h02, 8'h02, 8'h02, 8'h02, 8'h84};
    rst_n = 1'b0;
    b0.packet_enable = 1'b0;
    b0.video_field_end = 1'b0;
    b0.clk_audio_counter_wrap = 1'b0;
    b0.audio_valid = 1'b0;
    b0.acr_header = ACR_H;
    b0.acr_sub = ACR_S;
    b0.audio_header = AUD_H;
    b0.audio_sub = AUD_S;
    b0.avi_header = AVI_H;
    b0.avi_sub = AVI_S;
    b0.aif_header = AIF_H;
    b0.aif_sub = AIF_S;
    tick();
    tick();
    chk("rst_type", b0.packet_type, 8'h00);
    chk("rst_header", b0.header, 24'h0);
    chk("rst_sub", b0.sub, 224'h0);
    chk("rst_ready", b0.audio_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    // idle slots yield null packets
    for (int i = 0; i < 3; i++) begin
      slot(r0, r1);
      chk("idle_type", b0.packet_type, 8'h00);
      chk("idle_header", b0.header, 24'h0);
      chk("idle_ready", r0, 1'b0);
    end

    // ACR outranks audio
    b0.audio_valid = 1'b1;
    b0.clk_audio_counter_wrap = 1'b1;
    tick();
    slot(r0, r1);
    chk("acr_type", b0.packet_type, 8'h01);
    chk("acr_header", b0.header, ACR_H);
    chk("acr_sub", b0.sub, ACR_S);
    chk("acr_ready", r0, 1'b0);
    slot(r0, r1);
    chk("aud_type", b0.packet_type, 8'h02);
    chk("aud_header", b0.header, AUD_H);
    chk("aud_sub", b0.sub, AUD_S);
    chk("aud_ready", r0, 1'b1);
    chk("aud_ready_pulse", b0.audio_ready, 1'b0);

    // toggle coincides with an ACR-selecting slot: ACR goes twice
    b0.clk_audio_counter_wrap = 1'b0;
    tick();
    b0.clk_audio_counter_wrap = 1'b1;
    slot(r0, r1);
    chk("acr_same1", b0.packet_type, 8'h01);
    slot(r0, r1);
    chk("acr_same2", b0.packet_type, 8'h01);
    slot(r0, r1);
    chk("acr_same3", b0.packet_type, 8'h02);

    // starvation guard with audio held valid
    b0.video_field_end = 1'b1;
    tick();
    b0.video_field_end = 1'b0;
    for (int i = 0; i < 10; i++) begin
      slot(r0, r1);
      chk($sformatf("burst_type%0d", i), b0.packet_type, pat[i]);
      chk($sformatf("burst_ready%0d", i), r0, pat[i] == 8'h02);
    end
    slot(r0, r1);
    chk("post_burst", b0.packet_type, 8'h02);

    // reset between a wrap toggle and the next slot discards the ACR
    b0.clk_audio_counter_wrap = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_type", b0.packet_type, 8'h00);
    chk("async_header", b0.header, 24'h0);
    chk("async_sub", b0.sub, 224'h0);
    tick();
    rst_n = 1'b1;
    b0.audio_valid = 1'b0;
    tick();
    slot(r0, r1);
    chk("postrst_type", b0.packet_type, 8'h00);
    chk("postrst_ready", r0, 1'b0);

    // infoframes alone, with and without the audio infoframe
    b0.video_field_end = 1'b1;
    tick();
    b0.video_field_end = 1'b0;
    slot(r0, r1);
    chk("if_avi0", b0.packet_type, 8'h82);
    chk("if_avi0_hdr", b0.header, AVI_H);
    chk("if_avi0_sub", b0.sub, AVI_S);
    chk("if_avi1", b1.packet_type, 8'h82);
    b0.avi_header = 24'hFFFFFF;
    tick();
    chk("hold_header", b0.header, AVI_H);
    b0.avi_header = AVI_H;
    slot(r0, r1);
    chk("if_aif0", b0.packet_type, 8'h84);
    chk("if_aif0_hdr", b0.header, AIF_H);
    chk("if_aif0_sub", b0.sub, AIF_S);
    chk("if_null1", b1.packet_type, 8'h00);
    chk("if_null1_hdr", b1.header, 24'h0);
    slot(r0, r1);
    chk("if_null0", b0.packet_type, 8'h00);
    chk("if_null1b", b1.packet_type, 8'h00);
    chk("if_ready", r0 | r1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
